apb_master_fsm: RTL and testbench
=================================

# apb_master_fsm

Parametrised APB4 requester that turns a valid/ready command stream into protocol-correct SETUP/ACCESS sequences on an APB master port. It replaces the pass-through APB master glue with a registered, self-sequencing block that generates `psel`/`penable`, captures the read response and guards each ACCESS phase with a timeout. It sits between the bridge's AXI4-Lite-side control logic and the APB slave fabric.

## Interface
- `DATAWIDTH`, 32, APB data width; multiple of 8.
- `ADDRWIDTH`, 32, APB address width.
- `TIMEOUT`, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDRWIDTH  transfer address.
- `req_wdata`  in  DATAWIDTH  write data.
- `req_strb`  in  DATAWIDTH/8  write byte strobes.
- `req_prot`  in  3  protection attributes.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  DATAWIDTH  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  `pslverr` of the completed transfer, or 1 on timeout.
- `rsp_timeout`  out  1  transfer aborted by the timeout.
- `psel`, `penable`, `pwrite`  out  1 each  APB control.
- `paddr`  out  ADDRWIDTH; `pwdata`  out  DATAWIDTH; `pstrb`  out  DATAWIDTH/8; `pprot`  out  3.
- `pready`, `pslverr`  in  1 each; `prdata`  in  DATAWIDTH.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- `req_ready` = (state == IDLE) & (~`rsp_valid` | `rsp_ready`). It is combinational from registered state and `rsp_ready`.
- IDLE, on accept: register `addr`/`wdata`/`write`/`prot` onto the APB outputs. `pstrb` = `req_strb` for writes and all-zero for reads. Go to SETUP.
- SETUP: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1. The timeout counter increments every ACCESS cycle.
  - When `pready`=1: set `rsp_valid`. Set `rsp_rdata` = `prdata` (reads) or 0 (writes). Set `rsp_err` = `pslverr` and `rsp_timeout`=0. Go to IDLE and clear the counter.
  - When `pready`=0, `TIMEOUT`≠0, and this is the `TIMEOUT`-th ACCESS cycle: abort. Set `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. Go to IDLE.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1. It never wraps; it clears on leaving ACCESS.
- Response register: set on completion and held stable until the `rsp_valid & rsp_ready` handshake. If a completion and a consume land in the same cycle, the new response wins.
- `paddr`, `pwdata`, `pwrite`, `pprot`, `pstrb` hold their last value between transfers. They change only on command accept.
- `pready`, `pslverr`, `prdata` are ignored outside ACCESS.
- `req_*` inputs are ignored unless `req_valid & req_ready`.

## Timing
- Reset (`rst`=1 at an edge) sets every output to 0 and the state to IDLE. This covers `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot`, `rsp_valid`, `rsp_rdata`, `rsp_err` and `rsp_timeout`.
- Reset mid-transfer drops `psel`/`penable` on the next edge. It discards any pending response and generates no response for the aborted transfer.
- Accept in cycle 0 gives:
  - SETUP in cycle 1;
  - ACCESS in cycle 2;
  - `rsp_valid` in cycle 2+W+1, where W is the number of wait states (cycles with `pready`=0).
- Minimum command-to-response latency is 3 cycles.
- At least one IDLE cycle separates transfers: `psel`=0 for ≥1 cycle between transfers. Peak throughput is one transfer per 3 cycles.
- The earliest next accept is the first cycle `rsp_valid`=1, provided `rsp_ready`=1 in that same cycle.
- Timeout: with `pready` held 0, `psel`/`penable` are high for exactly `TIMEOUT` ACCESS cycles. `rsp_valid` rises on the following cycle.
- With `rsp_ready` held 0, at most one response is outstanding. `req_ready` stays 0 until that response is consumed.

## Test plan
- Write, zero wait, `rsp_ready`=1: addr 0x10, wdata 0xDEADBEEF, strb 0xF.
  - Required: `psel` high cycles 1–2, `penable` high cycle 2, `pstrb`=0xF.
  - Required in cycle 3: `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0.
- Read, 2 wait states: `prdata`=0x12345678 with `pready` in the 3rd ACCESS cycle.
  - Required: `pstrb`=0 throughout.
  - Required: `rsp_valid` in cycle 5 with `rsp_rdata`=0x12345678; `penable` high cycles 2–4.
- Slave error: read with `pslverr`=1 at `pready`.
  - Required: `rsp_err`=1 and `rsp_timeout`=0; `rsp_rdata` = `prdata`.
- Timeout, `TIMEOUT`=4, `pready` stuck 0.
  - Required: `penable` high exactly 4 cycles, then `psel`=0.
  - Required: `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Required: the next command completes normally.
- Response backpressure: `rsp_ready`=0 for 5 cycles after completion while `req_valid`=1.
  - Required: `req_ready`=0 and the response stays stable for those cycles.
  - Required: on the `rsp_ready` pulse, the next command is accepted in that same cycle.
- Reset in ACCESS: assert `rst` during wait states.
  - Required: all outputs 0 next cycle and no `rsp_valid`.
  - Required: a command after reset release completes with correct `paddr`.

Source files
------------

// File: rtl/apb_master_fsm.sv
// ---------------------------------------------------------------------------
// apb_master_fsm
//
// APB4 requester. Accepts one command at a time on a valid/ready stream,
// drives the SETUP/ACCESS sequence on the APB master port, captures the
// completion into a response register and aborts an ACCESS phase that runs
// for TIMEOUT cycles without pready (TIMEOUT = 0 disables the abort).
//
// Parameters
//   DATAWIDTH  APB data width (multiple of 8)
//   ADDRWIDTH  APB address width
//   TIMEOUT    ACCESS cycles allowed before abort, 0 = never abort
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          command handshake
//   req_write/addr/wdata/strb/prot  command payload
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_err/rsp_timeout   response payload
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot  APB requester outputs
//   pready/pslverr/prdata        APB completer inputs
// ---------------------------------------------------------------------------
module apb_master_fsm #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDRWIDTH-1:0]   req_addr,
    input  logic [DATAWIDTH-1:0]   req_wdata,
    input  logic [DATAWIDTH/8-1:0] req_strb,
    input  logic [2:0]             req_prot,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATAWIDTH-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,

    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDRWIDTH-1:0]   paddr,
    output logic [DATAWIDTH-1:0]   pwdata,
    output logic [DATAWIDTH/8-1:0] pstrb,
    output logic [2:0]             pprot,
    input  logic                   pready,
    input  logic                   pslverr,
    input  logic [DATAWIDTH-1:0]   prdata
);

    localparam int STRBWIDTH = DATAWIDTH / 8;
    localparam int CNTWIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen during the TIMEOUT-th ACCESS cycle (counter starts at 0).
    localparam logic [CNTWIDTH-1:0] LASTCOUNT =
        (TIMEOUT > 0) ? CNTWIDTH'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } stateT;

    stateT                 stateReg,      stateNext;
    logic [CNTWIDTH-1:0]   countReg,      countNext;
    logic                  pwriteReg,     pwriteNext;
    logic [ADDRWIDTH-1:0]  paddrReg,      paddrNext;
    logic [DATAWIDTH-1:0]  pwdataReg,     pwdataNext;
    logic [STRBWIDTH-1:0]  pstrbReg,      pstrbNext;
    logic [2:0]            pprotReg,      pprotNext;
    logic                  rspValidReg,   rspValidNext;
    logic [DATAWIDTH-1:0]  rspRdataReg,   rspRdataNext;
    logic                  rspErrReg,     rspErrNext;
    logic                  rspTimeoutReg, rspTimeoutNext;

    logic                  reqReady;
    logic                  accept;
    logic [STRBWIDTH-1:0]  strbMasked;

    // Reads carry no byte strobes on the bus.
    generate
        for (genvar gi = 0; gi < STRBWIDTH; gi++) begin : gStrb
            assign strbMasked[gi] = req_write & req_strb[gi];
        end
    endgenerate

    // A new command may start only once the previous response is gone or is
    // being consumed this very cycle.
    assign reqReady = (stateReg == IDLE) & (~rspValidReg | rsp_ready);
    assign accept   = req_valid & reqReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg      <= IDLE;
            countReg      <= '0;
            pwriteReg     <= 1'b0;
            paddrReg      <= '0;
            pwdataReg     <= '0;
            pstrbReg      <= '0;
            pprotReg      <= '0;
            rspValidReg   <= 1'b0;
            rspRdataReg   <= '0;
            rspErrReg     <= 1'b0;
            rspTimeoutReg <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            countReg      <= countNext;
            pwriteReg     <= pwriteNext;
            paddrReg      <= paddrNext;
            pwdataReg     <= pwdataNext;
            pstrbReg      <= pstrbNext;
            pprotReg      <= pprotNext;
            rspValidReg   <= rspValidNext;
            rspRdataReg   <= rspRdataNext;
            rspErrReg     <= rspErrNext;
            rspTimeoutReg <= rspTimeoutNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        countNext      = countReg;
        pwriteNext     = pwriteReg;
        paddrNext      = paddrReg;
        pwdataNext     = pwdataReg;
        pstrbNext      = pstrbReg;
        pprotNext      = pprotReg;
        rspValidNext   = rspValidReg;
        rspRdataNext   = rspRdataReg;
        rspErrNext     = rspErrReg;
        rspTimeoutNext = rspTimeoutReg;

        // Consume first; a completion below in the same cycle overrides it.
        if (rspValidReg && rsp_ready) begin
            rspValidNext = 1'b0;
        end

        case (stateReg)
            IDLE: begin
                if (accept) begin
                    pwriteNext = req_write;
                    paddrNext  = req_addr;
                    pwdataNext = req_wdata;
                    pstrbNext  = strbMasked;
                    pprotNext  = req_prot;
                    stateNext  = SETUP;
                end
            end

            SETUP: begin
                stateNext = ACCESS;
            end

            ACCESS: begin
                if (pready) begin
                    rspValidNext   = 1'b1;
                    rspRdataNext   = pwriteReg ? '0 : prdata;
                    rspErrNext     = pslverr;
                    rspTimeoutNext = 1'b0;
                    countNext      = '0;
                    stateNext      = IDLE;
                end else if ((TIMEOUT != 0) && (countReg == LASTCOUNT)) begin
                    rspValidNext   = 1'b1;
                    rspRdataNext   = '0;
                    rspErrNext     = 1'b1;
                    rspTimeoutNext = 1'b1;
                    countNext      = '0;
                    stateNext      = IDLE;
                end else if (countReg != '1) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    countNext = countReg + 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    assign req_ready   = reqReady;
    assign psel        = (stateReg == SETUP) | (stateReg == ACCESS);
    assign penable     = (stateReg == ACCESS);
    assign pwrite      = pwriteReg;
    assign paddr       = paddrReg;
    assign pwdata      = pwdataReg;
    assign pstrb       = pstrbReg;
    assign pprot       = pprotReg;
    assign rsp_valid   = rspValidReg;
    assign rsp_rdata   = rspRdataReg;
    assign rsp_err     = rspErrReg;
    assign rsp_timeout = rspTimeoutReg;

endmodule

// File: tb/tb_apb_master_fsm.sv
// ---------------------------------------------------------------------------
// tb_apb_master_fsm
//
// Directed bench for apb_master_fsm with TIMEOUT = 4. Inputs change 1 ns
// after a rising edge; outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_apb_master_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_master_fsm #(
        .DATAWIDTH (32),
        .ADDRWIDTH (32),
        .TIMEOUT   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_strb  = st;
        req_prot  = 3'b010;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; rsp_ready = 1'b1;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        tick();
        tick();
        rst = 1'b0;
        smp();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_pprot", pprot, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_req_ready", req_ready, 1);

        // Write, zero wait states.
        tick(); cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); smp();
        chk("wr_req_ready", req_ready, 1);
        tick(); req_valid = 1'b0; smp();
        chk("wr_c1_psel", psel, 1);
        chk("wr_c1_penable", penable, 0);
        chk("wr_c1_pwrite", pwrite, 1);
        chk("wr_c1_paddr", paddr, 32'h10);
        chk("wr_c1_pwdata", pwdata, 32'hDEADBEEF);
        chk("wr_c1_pstrb", pstrb, 4'hF);
        chk("wr_c1_pprot", pprot, 3'b010);
        tick(); pready = 1'b1; smp();
        chk("wr_c2_psel", psel, 1);
        chk("wr_c2_penable", penable, 1);
        // Cycle 3: response present and the next command goes in at once.
        tick(); pready = 1'b0; cmd(1'b0, 32'h20, 32'h0, 4'hA); smp();
        chk("wr_c3_rsp_valid", rsp_valid, 1);
        chk("wr_c3_rsp_err", rsp_err, 0);
        chk("wr_c3_rsp_rdata", rsp_rdata, 0);
        chk("wr_c3_rsp_timeout", rsp_timeout, 0);
        chk("wr_c3_psel", psel, 0);
        chk("rd_accept_same_cycle", req_ready, 1);
        $display("txn write addr=10 wdata=deadbeef rsp_err=%0d", rsp_err);

        // Read, two wait states; pslverr/prdata noise before pready is ignored.
        tick(); req_valid = 1'b0; prdata = 32'hBAD0BAD0; pslverr = 1'b1; smp();
        chk("rd_c1_psel", psel, 1);
        chk("rd_c1_penable", penable, 0);
        chk("rd_c1_pwrite", pwrite, 0);
        chk("rd_c1_paddr", paddr, 32'h20);
        chk("rd_c1_pstrb", pstrb, 0);
        chk("rd_c1_rsp_valid", rsp_valid, 0);
        tick(); smp();
        chk("rd_c2_penable", penable, 1);
        chk("rd_c2_pstrb", pstrb, 0);
        tick(); smp();
        chk("rd_c3_penable", penable, 1);
        tick(); pready = 1'b1; prdata = 32'h12345678; pslverr = 1'b0; smp();
        chk("rd_c4_penable", penable, 1);
        chk("rd_c4_rsp_valid", rsp_valid, 0);
        tick(); pready = 1'b0; cmd(1'b0, 32'h30, 32'h0, 4'h0); smp();
        chk("rd_c5_rsp_valid", rsp_valid, 1);
        chk("rd_c5_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("rd_c5_rsp_err", rsp_err, 0);
        chk("rd_c5_psel", psel, 0);
        chk("rd_c5_pstrb", pstrb, 0);
        $display("txn read addr=20 rdata=%h", rsp_rdata);

        // Read with slave error.
        tick(); req_valid = 1'b0; smp();
        chk("err_c1_psel", psel, 1);
        chk("err_c1_paddr", paddr, 32'h30);
        tick(); pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE0001; smp();
        chk("err_c2_penable", penable, 1);
        tick(); pready = 1'b0; pslverr = 1'b0; smp();
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_timeout", rsp_timeout, 0);
        chk("err_rsp_rdata", rsp_rdata, 32'hCAFE0001);
        $display("txn read addr=30 rdata=%h rsp_err=%0d", rsp_rdata, rsp_err);

        // Timeout: pready stuck low for a read.
        tick(); cmd(1'b0, 32'h40, 32'h0, 4'h0); prdata = 32'hFFFFFFFF; smp();
        chk("to_req_ready", req_ready, 1);
        tick(); req_valid = 1'b0; smp();
        chk("to_c1_psel", psel, 1);
        chk("to_c1_penable", penable, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); smp();
            chk("to_access_psel", psel, 1);
            chk("to_access_penable", penable, 1);
            chk("to_access_rsp_valid", rsp_valid, 0);
        end
        tick(); cmd(1'b1, 32'h50, 32'hA5A5A5A5, 4'h3); smp();
        chk("to_end_psel", psel, 0);
        chk("to_end_penable", penable, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_next_req_ready", req_ready, 1);
        $display("txn read addr=40 timeout=%0d", rsp_timeout);

        // Command after the timeout completes normally.
        tick(); req_valid = 1'b0; smp();
        chk("post_to_psel", psel, 1);
        chk("post_to_paddr", paddr, 32'h50);
        chk("post_to_pstrb", pstrb, 4'h3);
        chk("post_to_rsp_valid", rsp_valid, 0);
        tick(); pready = 1'b1; smp();
        chk("post_to_penable", penable, 1);
        tick(); pready = 1'b0; smp();
        chk("post_to_rsp_valid2", rsp_valid, 1);
        chk("post_to_rsp_err", rsp_err, 0);
        chk("post_to_rsp_timeout", rsp_timeout, 0);
        chk("post_to_rsp_rdata", rsp_rdata, 0);
        $display("txn write addr=50 rsp_err=%0d", rsp_err);

        // Response backpressure.
        tick(); cmd(1'b0, 32'h60, 32'h0, 4'h0); smp();
        chk("bp_req_ready", req_ready, 1);
        tick(); req_valid = 1'b0; smp();
        tick(); pready = 1'b1; prdata = 32'h55AA55AA; smp();
        tick(); pready = 1'b0; prdata = 32'h0; rsp_ready = 1'b0;
        cmd(1'b1, 32'h70, 32'h0BADCAFE, 4'hC); smp();
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                tick(); smp();
            end
            chk("bp_hold_rsp_valid", rsp_valid, 1);
            chk("bp_hold_rsp_rdata", rsp_rdata, 32'h55AA55AA);
            chk("bp_hold_rsp_err", rsp_err, 0);
            chk("bp_hold_req_ready", req_ready, 0);
            chk("bp_hold_psel", psel, 0);
        end
        $display("txn read addr=60 rdata=%h held 5 cycles", rsp_rdata);
        tick(); rsp_ready = 1'b1; smp();
        chk("bp_release_req_ready", req_ready, 1);
        chk("bp_release_rsp_valid", rsp_valid, 1);
        tick(); req_valid = 1'b0; smp();
        chk("bp_next_psel", psel, 1);
        chk("bp_next_paddr", paddr, 32'h70);
        chk("bp_next_pwdata", pwdata, 32'h0BADCAFE);
        chk("bp_next_rsp_valid", rsp_valid, 0);

        // Reset during wait states of the 0x70 write.
        tick(); smp();
        chk("rs_access_penable", penable, 1);
        tick(); rst = 1'b1; smp();
        chk("rs_wait_penable", penable, 1);
        tick(); rst = 1'b0; pready = 1'b1; smp();
        chk("rs_psel", psel, 0);
        chk("rs_penable", penable, 0);
        chk("rs_pwrite", pwrite, 0);
        chk("rs_paddr", paddr, 0);
        chk("rs_pwdata", pwdata, 0);
        chk("rs_pstrb", pstrb, 0);
        chk("rs_pprot", pprot, 0);
        chk("rs_rsp_valid", rsp_valid, 0);
        chk("rs_rsp_rdata", rsp_rdata, 0);
        chk("rs_rsp_err", rsp_err, 0);
        chk("rs_rsp_timeout", rsp_timeout, 0);
        tick(); smp();
        chk("rs_after_rsp_valid", rsp_valid, 0);
        chk("rs_after_psel", psel, 0);
        $display("txn write addr=70 aborted by reset");

        // Command after reset release.
        tick(); pready = 1'b0; cmd(1'b0, 32'h80, 32'h0, 4'h0); smp();
        chk("ar_req_ready", req_ready, 1);
        tick(); req_valid = 1'b0; smp();
        chk("ar_psel", psel, 1);
        chk("ar_paddr", paddr, 32'h80);
        tick(); pready = 1'b1; prdata = 32'h80808080; smp();
        chk("ar_penable", penable, 1);
        tick(); pready = 1'b0; smp();
        chk("ar_rsp_valid", rsp_valid, 1);
        chk("ar_rsp_rdata", rsp_rdata, 32'h80808080);
        chk("ar_rsp_err", rsp_err, 0);
        $display("txn read addr=80 rdata=%h", rsp_rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
